// File: rtl/ex_stage.sv
// RV32I execute stage: decodes OP / OP-IMM / LUI / AUIPC into ALU controls and
// registers the result into a one-entry EX/MEM register with valid/ready flow control.
`timescale 1ns/1ps

module alu #(
    parameter int N_BITS = 32
) (
    input  logic [N_BITS-1:0] in0,
    input  logic [N_BITS-1:0] in1,
    input  logic [3:0]        op,
    output logic [N_BITS-1:0] out
);
    logic [4:0] shamt;
    assign shamt = in1[4:0];

    // Unused encodings fall through to zero rather than aliasing a real operation
    always_comb begin
        out = '0;
        case (op)
            4'b0000: out = in0 + in1;
            4'b0001: out = in0 - in1;
            4'b0010: out = in0 << shamt;
            4'b0100: out = {{(N_BITS-1){1'b0}}, ($signed(in0) < $signed(in1))};
            4'b0110: out = {{(N_BITS-1){1'b0}}, (in0 < in1)};
            4'b1000: out = in0 ^ in1;
            4'b1010: out = in0 >> shamt;
            4'b1011: out = $unsigned($signed(in0) >>> shamt);
            4'b1100: out = in0 | in1;
            4'b1110: out = in0 & in1;
            default: out = '0;
        endcase
    end
endmodule

module ex_stage #(
    parameter int N_BITS = 32,
    parameter int N_REGS = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    output logic                      id_ready,
    input  logic [31:0]               id_instr,
    input  logic [N_BITS-1:0]         id_pc,
    input  logic [N_BITS-1:0]         id_rs1_data,
    input  logic [N_BITS-1:0]         id_rs2_data,
    input  logic                      flush,
    output logic                      ex_valid,
    input  logic                      mem_ready,
    output logic [N_BITS-1:0]         ex_result,
    output logic [$clog2(N_REGS)-1:0] ex_rd_addr,
    output logic                      ex_rd_we,
    output logic                      ex_illegal,
    output logic [31:0]               ex_retired
);
    localparam int RD_W = $clog2(N_REGS);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [RD_W-1:0]   rd;
    logic [N_BITS-1:0] i_imm;
    logic [N_BITS-1:0] u_imm;
    logic [3:0]        alu_op;
    logic [N_BITS-1:0] alu_in0;
    logic [N_BITS-1:0] alu_in1;
    logic [N_BITS-1:0] alu_out;
    logic              legal;
    logic              accept;

    assign opcode = id_instr[6:0];
    assign funct3 = id_instr[14:12];
    assign rd     = id_instr[RD_W+6:7];
    assign i_imm  = {{20{id_instr[31]}}, id_instr[31:20]};
    assign u_imm  = {id_instr[31:12], 12'b0};

    assign id_ready = !ex_valid || mem_ready;
    assign accept   = id_valid && id_ready;

    // For OP-IMM, instr[30] is an immediate bit except on SRAI, so ADDI never subtracts
    always_comb begin
        alu_op  = 4'b0000;
        alu_in0 = '0;
        alu_in1 = '0;
        legal   = 1'b0;
        case (opcode)
            OPC_OP: begin
                alu_op  = {funct3, id_instr[30]};
                alu_in0 = id_rs1_data;
                alu_in1 = id_rs2_data;
                legal   = 1'b1;
            end
            OPC_OP_IMM: begin
                alu_op  = {funct3, (funct3 == 3'b101) ? id_instr[30] : 1'b0};
                alu_in0 = id_rs1_data;
                alu_in1 = i_imm;
                legal   = 1'b1;
            end
            OPC_LUI: begin
                alu_in1 = u_imm;
                legal   = 1'b1;
            end
            OPC_AUIPC: begin
                alu_in0 = id_pc;
                alu_in1 = u_imm;
                legal   = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    alu #(.N_BITS(N_BITS)) u_alu (
        .in0 (alu_in0),
        .in1 (alu_in1),
        .op  (alu_op),
        .out (alu_out)
    );

    // Retirement is counted independently of flush; flush outranks a new accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_result  <= '0;
            ex_rd_addr <= '0;
            ex_rd_we   <= 1'b0;
            ex_illegal <= 1'b0;
            ex_retired <= '0;
        end else begin
            if (ex_valid && mem_ready)
                ex_retired <= ex_retired + 32'd1;
            if (flush) begin
                ex_valid <= 1'b0;
                ex_rd_we <= 1'b0;
            end else if (accept) begin
                ex_valid   <= 1'b1;
                ex_result  <= legal ? alu_out : '0;
                ex_rd_addr <= rd;
                ex_rd_we   <= legal && (rd != '0);
                ex_illegal <= !legal;
            end else if (ex_valid && mem_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end
endmodule
